// File: rtl/mc_pkg.sv
// Shared types and constants for the multi-cycle RV32I control sequencer.
// Imported by mc_opdecode and mc_control_fsm.
package mc_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC_R,
    EXEC_I,
    MEM_ADDR,
    MEM_RD,
    MEM_WR,
    WB_ALU,
    WB_LD,
    BRANCH,
    TRAP
  } state_e;

  typedef enum logic [1:0] {
    CLS_R,
    CLS_I,
    CLS_MEM,
    CLS_BR
  } op_class_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_BR   = 2'b01;
  localparam logic [1:0] ALU_RTYP = 2'b10;
  localparam logic [1:0] ALU_ITYP = 2'b11;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_ILL  = 2'b01;
  localparam logic [1:0] CAUSE_IMEM = 2'b10;
  localparam logic [1:0] CAUSE_DMEM = 2'b11;

endpackage

// File: rtl/mc_opdecode.sv
// Opcode classifier used by the sequencer in DECODE.
// Maps the IR opcode to an execution class plus an illegal flag.
module mc_opdecode
  import mc_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_e  op_class,
  output logic       illegal
);

  // One-hot style match on the supported opcodes
  always_comb begin
    op_class = CLS_R;
    illegal  = 1'b0;
    unique case (1'b1)
      (opcode == OP_R):      op_class = CLS_R;
      (opcode == OP_I):      op_class = CLS_I;
      (opcode == OP_LOAD):   op_class = CLS_MEM;
      (opcode == OP_STORE):  op_class = CLS_MEM;
      (opcode == OP_BRANCH): op_class = CLS_BR;
      default:               illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control sequencer for the RV32I ALU/branch datapath.
// Optional retired-instruction counter: define MC_RETIRE_COUNT_EN.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [6:0] opcode,
  input  logic       zero_flag,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic [1:0] aluop,
  output logic       alusrc,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       retire,
  output logic       trap,
  output logic [1:0] trap_cause
`ifdef MC_RETIRE_COUNT_EN
  ,
  output logic [CNT_W-1:0] instret
`endif
);

  localparam int WAIT_W =
    (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e            state_q;
  state_e            state_d;
  logic [WAIT_W-1:0] wait_q;
  logic [1:0]        cause_q;
  logic [1:0]        cause_d;
  logic              waiting;
  logic              tmo_hit;
  op_class_e         dec_class;
  logic              dec_ill;
  state_e            ret_next;

  mc_opdecode u_opdecode (
    .opcode   (opcode),
    .op_class (dec_class),
    .illegal  (dec_ill)
  );

  // The 16th consecutive wait cycle is the last one allowed
  assign waiting  = (state_q == FETCH)
                 || (state_q == MEM_RD)
                 || (state_q == MEM_WR);
  assign tmo_hit  = (TIMEOUT != 0) && (wait_q == WAIT_LAST);
  assign ret_next = run ? FETCH : IDLE;

  // State, wait counter and latched trap cause
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wait_q  <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        wait_q <= '0;
      end else if (waiting) begin
        wait_q <= wait_q + 1'b1;
      end
      if (state_d == TRAP && state_q != TRAP) begin
        cause_q <= cause_d;
      end
    end
  end

  // Next state and Moore-decoded datapath controls
  always_comb begin
    state_d    = state_q;
    cause_d    = CAUSE_NONE;
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    aluop      = ALU_ADD;
    alusrc     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    retire     = 1'b0;
    trap       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end else if (tmo_hit) begin
          state_d = TRAP;
          cause_d = CAUSE_IMEM;
        end
      end
      DECODE: begin
        if (dec_ill) begin
          state_d = TRAP;
          cause_d = CAUSE_ILL;
        end else begin
          unique case (dec_class)
            CLS_R:   state_d = EXEC_R;
            CLS_I:   state_d = EXEC_I;
            CLS_MEM: state_d = MEM_ADDR;
            default: state_d = BRANCH;
          endcase
        end
      end
      EXEC_R: begin
        aluop   = ALU_RTYP;
        state_d = WB_ALU;
      end
      EXEC_I: begin
        aluop   = ALU_ITYP;
        alusrc  = 1'b1;
        state_d = WB_ALU;
      end
      MEM_ADDR: begin
        alusrc  = 1'b1;
        state_d = opcode[5] ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        alusrc   = 1'b1;
        mem_read = 1'b1;
        if (dmem_ready) begin
          state_d = WB_LD;
        end else if (tmo_hit) begin
          state_d = TRAP;
          cause_d = CAUSE_DMEM;
        end
      end
      MEM_WR: begin
        alusrc    = 1'b1;
        mem_write = 1'b1;
        if (dmem_ready) begin
          retire  = 1'b1;
          state_d = ret_next;
        end else if (tmo_hit) begin
          state_d = TRAP;
          cause_d = CAUSE_DMEM;
        end
      end
      WB_ALU: begin
        // opcode still in the IR tells which ALU setup to hold
        aluop     = (opcode == OP_I) ? ALU_ITYP : ALU_RTYP;
        alusrc    = (opcode == OP_I);
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = ret_next;
      end
      WB_LD: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = ret_next;
      end
      BRANCH: begin
        aluop    = ALU_BR;
        pc_src   = 1'b1;
        pc_write = zero_flag;
        retire   = 1'b1;
        state_d  = ret_next;
      end
      TRAP: begin
        trap = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign trap_cause = cause_q;

`ifdef MC_RETIRE_COUNT_EN
  // Retired-instruction count; wraps, and no retires occur in TRAP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret <= '0;
    end else if (retire) begin
      instret <= instret + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm.
// Define MC_RETIRE_COUNT_EN to also exercise instret.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [6:0] opcode = 7'h0;
  logic       zero_flag = 1'b0;
  logic       imem_ready = 1'b0;
  logic       dmem_ready = 1'b0;
  logic       imem_req, ir_write, pc_write, pc_src;
  logic [1:0] aluop;
  logic       alusrc, mem_read, mem_write;
  logic       reg_write, mem_to_reg, retire, trap;
  logic [1:0] trap_cause;
`ifdef MC_RETIRE_COUNT_EN
  logic [3:0] instret;
`endif

  int tests = 0;
  int fails = 0;

  // {req,irw,pcw,pcsrc}_aluop_alusrc_{rd,wr}_{regw,m2r,ret}_trap_cause
  localparam logic [14:0] O_IDLE = 15'b0000_00_0_00_000_0_00;
  localparam logic [14:0] O_FRDY = 15'b1110_00_0_00_000_0_00;
  localparam logic [14:0] O_FWT  = 15'b1000_00_0_00_000_0_00;
  localparam logic [14:0] O_DEC  = 15'b0000_00_0_00_000_0_00;
  localparam logic [14:0] O_EXR  = 15'b0000_10_0_00_000_0_00;
  localparam logic [14:0] O_EXI  = 15'b0000_11_1_00_000_0_00;
  localparam logic [14:0] O_WBR  = 15'b0000_10_0_00_101_0_00;
  localparam logic [14:0] O_WBI  = 15'b0000_11_1_00_101_0_00;
  localparam logic [14:0] O_MAD  = 15'b0000_00_1_00_000_0_00;
  localparam logic [14:0] O_MRD  = 15'b0000_00_1_10_000_0_00;
  localparam logic [14:0] O_MWW  = 15'b0000_00_1_01_000_0_00;
  localparam logic [14:0] O_MWD  = 15'b0000_00_1_01_001_0_00;
  localparam logic [14:0] O_WBL  = 15'b0000_00_0_00_111_0_00;
  localparam logic [14:0] O_BR1  = 15'b0011_01_0_00_001_0_00;
  localparam logic [14:0] O_BR0  = 15'b0001_01_0_00_001_0_00;
  localparam logic [14:0] O_TILL = 15'b0000_00_0_00_000_1_01;
  localparam logic [14:0] O_TIM  = 15'b0000_00_0_00_000_1_10;
  localparam logic [14:0] O_TDM  = 15'b0000_00_0_00_000_1_11;

  mc_control_fsm #(
    .TIMEOUT (16),
`ifdef MC_RETIRE_COUNT_EN
    .CNT_W   (4)
`else
    .CNT_W   (32)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .opcode     (opcode),
    .zero_flag  (zero_flag),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .imem_req   (imem_req),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .aluop      (aluop),
    .alusrc     (alusrc),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .retire     (retire),
    .trap       (trap),
    .trap_cause (trap_cause)
`ifdef MC_RETIRE_COUNT_EN
    ,
    .instret    (instret)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] obs();
    return {imem_req, ir_write, pc_write, pc_src,
            aluop, alusrc, mem_read, mem_write,
            reg_write, mem_to_reg, retire,
            trap, trap_cause};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [6:0] op);
    rst_n      = 1'b0;
    run        = 1'b1;
    opcode     = op;
    zero_flag  = 1'b0;
    imem_ready = 1'b1;
    dmem_ready = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    run = 1'b1;
    imem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests++;
      if (obs() !== O_IDLE) begin
        fails++;
        $display("FAIL reset cyc%0d got %b want %b",
                 i, obs(), O_IDLE);
      end
      tick();
    end
  endtask

  task automatic test_rtype();
    logic [14:0] ex [6];
    ex = '{O_IDLE, O_FRDY, O_DEC, O_EXR, O_WBR, O_FRDY};
    do_reset(7'b0110011);
    for (int i = 0; i < 6; i++) begin
      #1;
      tests++;
      if (obs() !== ex[i]) begin
        fails++;
        $display("FAIL rtype cyc%0d got %b want %b",
                 i, obs(), ex[i]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [14:0] ex [10];
    logic [6:0]  op [10];
    logic        rn [10];
    ex = '{O_IDLE, O_FRDY, O_DEC, O_EXR, O_WBR,
           O_FRDY, O_DEC, O_EXI, O_WBI, O_IDLE};
    op = '{7'h33, 7'h33, 7'h33, 7'h33, 7'h33,
           7'h13, 7'h13, 7'h13, 7'h13, 7'h13};
    rn = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
           1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset(7'b0110011);
    for (int i = 0; i < 10; i++) begin
      opcode = op[i];
      run = rn[i];
      #1;
      tests++;
      if (obs() !== ex[i]) begin
        fails++;
        $display("FAIL b2b cyc%0d got %b want %b",
                 i, obs(), ex[i]);
      end
      tick();
    end
  endtask

  task automatic test_load();
    logic [14:0] ex [11];
    logic        dm [11];
    logic        rn [11];
    ex = '{O_IDLE, O_FRDY, O_DEC, O_MAD, O_MRD, O_MRD,
           O_MRD, O_MRD, O_WBL, O_IDLE, O_IDLE};
    dm = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    rn = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
    do_reset(7'b0000011);
    for (int i = 0; i < 11; i++) begin
      dmem_ready = dm[i];
      run = rn[i];
      #1;
      tests++;
      if (obs() !== ex[i]) begin
        fails++;
        $display("FAIL load cyc%0d got %b want %b",
                 i, obs(), ex[i]);
      end
      tick();
    end
  endtask

  task automatic test_store();
    logic [14:0] ex [11];
    logic        dm [11];
    logic        rn [11];
    ex = '{O_IDLE, O_FRDY, O_DEC, O_MAD, O_MWW, O_MWD,
           O_FRDY, O_DEC, O_MAD, O_MWD, O_IDLE};
    dm = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
    rn = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    do_reset(7'b0100011);
    for (int i = 0; i < 11; i++) begin
      dmem_ready = dm[i];
      run = rn[i];
      #1;
      tests++;
      if (obs() !== ex[i]) begin
        fails++;
        $display("FAIL store cyc%0d got %b want %b",
                 i, obs(), ex[i]);
      end
      tick();
    end
  endtask

  task automatic test_branch();
    logic [14:0] ex [8];
    logic        zf [8];
    logic        rn [8];
    ex = '{O_IDLE, O_FRDY, O_DEC, O_BR1,
           O_FRDY, O_DEC, O_BR0, O_IDLE};
    zf = '{0, 0, 0, 1, 1, 1, 0, 0};
    rn = '{1, 1, 1, 1, 1, 1, 0, 0};
    do_reset(7'b1100011);
    for (int i = 0; i < 8; i++) begin
      zero_flag = zf[i];
      run = rn[i];
      #1;
      tests++;
      if (obs() !== ex[i]) begin
        fails++;
        $display("FAIL branch cyc%0d got %b want %b",
                 i, obs(), ex[i]);
      end
      tick();
    end
  endtask

  task automatic test_illegal();
    logic [14:0] ex [9];
    logic        rn [9];
    ex = '{O_IDLE, O_FRDY, O_DEC, O_TILL, O_TILL,
           O_TILL, O_TILL, O_TILL, O_TILL};
    rn = '{1, 1, 1, 0, 1, 0, 1, 1, 0};
    do_reset(7'b1111111);
    dmem_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      run = rn[i];
      #1;
      tests++;
      if (obs() !== ex[i]) begin
        fails++;
        $display("FAIL illegal cyc%0d got %b want %b",
                 i, obs(), ex[i]);
      end
      tick();
    end
  endtask

  task automatic test_imem_timeout();
    logic [14:0] ex;
    do_reset(7'b0110011);
    imem_ready = 1'b0;
    for (int i = 0; i < 19; i++) begin
      ex = (i == 0) ? O_IDLE : (i <= 16) ? O_FWT : O_TIM;
      #1;
      tests++;
      if (obs() !== ex) begin
        fails++;
        $display("FAIL imem_tmo cyc%0d got %b want %b",
                 i, obs(), ex);
      end
      tick();
    end
  endtask

  task automatic test_imem_ready_edge();
    logic [14:0] ex;
    do_reset(7'b0110011);
    imem_ready = 1'b0;
    for (int i = 0; i < 19; i++) begin
      imem_ready = (i >= 16);
      ex = (i == 0)  ? O_IDLE :
           (i < 16)  ? O_FWT  :
           (i == 16) ? O_FRDY :
           (i == 17) ? O_DEC  : O_EXR;
      #1;
      tests++;
      if (obs() !== ex) begin
        fails++;
        $display("FAIL imem_edge cyc%0d got %b want %b",
                 i, obs(), ex);
      end
      tick();
    end
  endtask

  task automatic test_dmem_timeout();
    logic [14:0] ex;
    do_reset(7'b0100011);
    for (int i = 0; i < 22; i++) begin
      ex = (i == 0) ? O_IDLE :
           (i == 1) ? O_FRDY :
           (i == 2) ? O_DEC  :
           (i == 3) ? O_MAD  :
           (i <= 19) ? O_MWW : O_TDM;
      #1;
      tests++;
      if (obs() !== ex) begin
        fails++;
        $display("FAIL dmem_tmo cyc%0d got %b want %b",
                 i, obs(), ex);
      end
      tick();
    end
  endtask

  task automatic test_midop_reset();
    do_reset(7'b0000011);
    repeat (4) tick();
    #1;
    tests++;
    if (obs() !== O_MRD) begin
      fails++;
      $display("FAIL midop_pre got %b want %b",
               obs(), O_MRD);
    end
    rst_n = 1'b0;
    #2;
    tests++;
    if (obs() !== O_IDLE) begin
      fails++;
      $display("FAIL midop_async got %b want %b",
               obs(), O_IDLE);
    end
    run = 1'b0;
    dmem_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests++;
      if (obs() !== O_IDLE) begin
        fails++;
        $display("FAIL midop_post cyc%0d got %b want %b",
                 i, obs(), O_IDLE);
      end
      tick();
    end
  endtask

`ifdef MC_RETIRE_COUNT_EN
  task automatic test_instret();
    do_reset(7'b0100011);
    dmem_ready = 1'b1;
    for (int c = 0; c < 71; c++) begin
      run = (c < 67);
      #1;
      if (c == 0 || c == 65) begin
        tests++;
        if (instret !== 4'd0) begin
          fails++;
          $display("FAIL instret c%0d got %0d want 0",
                   c, instret);
        end
      end
      if (c == 69 || c == 70) begin
        tests++;
        if (instret !== 4'd1 || obs() !== O_IDLE) begin
          fails++;
          $display("FAIL instret_end c%0d got %0d/%b want 1/%b",
                   c, instret, obs(), O_IDLE);
        end
      end
      tick();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rtype();
    test_back_to_back();
    test_load();
    test_store();
    test_branch();
    test_illegal();
    test_imem_timeout();
    test_imem_ready_edge();
    test_dmem_timeout();
    test_midop_reset();
`ifdef MC_RETIRE_COUNT_EN
    test_instret();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
